addr_translator: RTL and testbench



---
 rtl/addr_translator.sv | 275 +++++++++++++++++++++++++++
 tb/tb_addr_translator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_translator.sv
// ----------------------------------------------------------------------------
// addr_translator_pkg / addr_translator
//
// Purpose:
//   Virtual-to-physical address translation for one access per cycle.
//   Supports direct address mode, two direct-mapped windows (DMW0/DMW1)
//   and a fully associative TLB search. Address and exception outputs are
//   purely combinational. The only state is a counter of the TLB-refill
//   exceptions that have been reported.
//
// Ports:
//   clk          in   clock (drives the miss counter only)
//   rst          in   asynchronous active-high reset of the miss counter
//   en           in   lookup request; gates excp and the miss counter
//   va           in   [31:0] virtual address
//   lookup_type  in   [1:0] 00 FETCH, 01 LOAD, 10 STORE
//   byte_type    in   [1:0] 00 BYTE, 01 HALF_WORD, 10 WORD, 11 reserved
//   rd_csr       in   csr_t snapshot (crmd, dmw0, dmw1, asid)
//   tlb_entrys   in   tlb_entry_t [TLB_ENTRY_NUM]
//   mat          out  [1:0] memory access type (bit0 = cacheable)
//   pa           out  [31:0] physical address
//   excp         out  excp_pass_t {valid, ecode, esubcode, badv}
//   tlb_miss_cnt out  [31:0] number of TLB-refill exceptions reported
// ----------------------------------------------------------------------------
package addr_translator_pkg;

    localparam logic [1:0] LT_FETCH = 2'b00;
    localparam logic [1:0] LT_LOAD  = 2'b01;
    localparam logic [1:0] LT_STORE = 2'b10;

    localparam logic [1:0] BT_BYTE  = 2'b00;
    localparam logic [1:0] BT_HALF  = 2'b01;
    localparam logic [1:0] BT_WORD  = 2'b10;

    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef struct packed {
        logic       da;
        logic       pg;
        logic [1:0] plv;
        logic [1:0] datf;
        logic [1:0] datm;
    } crmd_t;

    typedef struct packed {
        logic       plv0;
        logic       plv3;
        logic [1:0] mat;
        logic [2:0] pseg;
        logic [2:0] vseg;
    } dmw_t;

    typedef struct packed {
        logic [9:0] asid;
    } asid_t;

    typedef struct packed {
        crmd_t crmd;
        dmw_t  dmw0;
        dmw_t  dmw1;
        asid_t asid;
    } csr_t;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic        e;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic [18:0] vppn;
        tlb_page_t   p0;    // even page
        tlb_page_t   p1;    // odd page
    } tlb_entry_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] badv;
    } excp_pass_t;

endpackage

module addr_translator
    import addr_translator_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] va,
    input  logic [1:0]  lookup_type,
    input  logic [1:0]  byte_type,
    input  csr_t        rd_csr,
    input  tlb_entry_t  tlb_entrys [TLB_ENTRY_NUM],
    output logic [1:0]  mat,
    output logic [31:0] pa,
    output excp_pass_t  excp,
    output logic [31:0] tlb_miss_cnt
);

    // ------------------------------------------------------------------
    // Mode and DMW decode
    // ------------------------------------------------------------------
    logic direct_mode;
    logic dmw0_hit;
    logic dmw1_hit;
    logic tlb_path;
    logic plv_is0;
    logic plv_is3;

    // da=0 with pg=0 is not a legal paging state; fall back to direct.
    assign direct_mode = rd_csr.crmd.da | ~rd_csr.crmd.pg;
    assign plv_is0     = (rd_csr.crmd.plv == 2'd0);
    assign plv_is3     = (rd_csr.crmd.plv == 2'd3);

    assign dmw0_hit = ~direct_mode
                    & (va[31:29] == rd_csr.dmw0.vseg)
                    & ((plv_is0 & rd_csr.dmw0.plv0) | (plv_is3 & rd_csr.dmw0.plv3));
    assign dmw1_hit = ~direct_mode
                    & (va[31:29] == rd_csr.dmw1.vseg)
                    & ((plv_is0 & rd_csr.dmw1.plv0) | (plv_is3 & rd_csr.dmw1.plv3));

    assign tlb_path = ~direct_mode & ~dmw0_hit & ~dmw1_hit;

    // ------------------------------------------------------------------
    // TLB search: per-entry compare, then a lowest-index-wins one-hot
    // select built as a prefix chain so the mux is a plain OR tree.
    // ------------------------------------------------------------------
    logic [TLB_ENTRY_NUM-1:0] match_vec;
    logic [TLB_ENTRY_NUM:0]   seen_chain;
    tlb_entry_t               sel_chain [TLB_ENTRY_NUM+1];

    assign seen_chain[0] = 1'b0;
    assign sel_chain[0]  = '0;

    generate
        for (genvar gi = 0; gi < TLB_ENTRY_NUM; gi++) begin : g_tlb
            logic asid_ok;
            logic vppn_ok;
            logic first_hit;

            assign asid_ok = tlb_entrys[gi].g
                           | (tlb_entrys[gi].asid == rd_csr.asid.asid);
            // Any page size other than 4 KiB is compared at 4 MiB granularity.
            assign vppn_ok = (tlb_entrys[gi].ps == 6'd12)
                           ? (va[31:13] == tlb_entrys[gi].vppn)
                           : (va[31:22] == tlb_entrys[gi].vppn[18:9]);
            assign match_vec[gi] = tlb_entrys[gi].e & asid_ok & vppn_ok;

            assign first_hit          = match_vec[gi] & ~seen_chain[gi];
            assign seen_chain[gi + 1] = seen_chain[gi] | match_vec[gi];
            assign sel_chain[gi + 1]  = sel_chain[gi] | (first_hit ? tlb_entrys[gi] : '0);
        end
    endgenerate

    logic       tlb_hit;
    tlb_entry_t hit_entry;
    logic       ps_small;
    logic       odd_sel;
    tlb_page_t  hit_page;
    logic [31:0] tlb_pa;

    assign tlb_hit   = seen_chain[TLB_ENTRY_NUM];
    assign hit_entry = sel_chain[TLB_ENTRY_NUM];
    assign ps_small  = (hit_entry.ps == 6'd12);
    assign odd_sel   = ps_small ? va[12] : va[21];
    assign hit_page  = odd_sel ? hit_entry.p1 : hit_entry.p0;
    assign tlb_pa    = ps_small ? {hit_page.ppn, va[11:0]}
                                : {hit_page.ppn[19:9], va[20:0]};

    // ------------------------------------------------------------------
    // Address / memory type
    // ------------------------------------------------------------------
    always_comb begin
        pa  = va;
        mat = 2'd0;
        if (direct_mode) begin
            mat = (lookup_type == LT_FETCH) ? rd_csr.crmd.datf : rd_csr.crmd.datm;
        end else if (dmw0_hit) begin
            pa  = {rd_csr.dmw0.pseg, va[28:0]};
            mat = rd_csr.dmw0.mat;
        end else if (dmw1_hit) begin
            pa  = {rd_csr.dmw1.pseg, va[28:0]};
            mat = rd_csr.dmw1.mat;
        end else if (tlb_hit) begin
            pa  = tlb_pa;
            mat = hit_page.mat;
        end
    end

    // ------------------------------------------------------------------
    // Exceptions, highest priority first
    // ------------------------------------------------------------------
    logic       is_fetch;
    logic       is_store;
    logic       is_mem;
    logic       misaligned;
    logic       raw_valid;
    logic [5:0] raw_ecode;

    assign is_fetch   = (lookup_type == LT_FETCH);
    assign is_store   = (lookup_type == LT_STORE);
    assign is_mem     = (lookup_type == LT_LOAD) | is_store;
    assign misaligned = ((byte_type == BT_HALF) & va[0])
                      | ((byte_type == BT_WORD) & (va[1:0] != 2'b00));

    always_comb begin
        raw_valid = 1'b0;
        raw_ecode = 6'd0;
        if (is_fetch && (va[1:0] != 2'b00)) begin
            raw_valid = 1'b1;
            raw_ecode = ECODE_ADEF;
        end else if (is_mem && misaligned) begin
            raw_valid = 1'b1;
            raw_ecode = ECODE_ALE;
        end else if (tlb_path && !tlb_hit) begin
            raw_valid = 1'b1;
            raw_ecode = ECODE_TLBR;
        end else if (tlb_path && !hit_page.v) begin
            raw_valid = 1'b1;
            raw_ecode = is_fetch ? ECODE_PIF : (is_store ? ECODE_PIS : ECODE_PIL);
        end else if (tlb_path && (rd_csr.crmd.plv > hit_page.plv)) begin
            raw_valid = 1'b1;
            raw_ecode = ECODE_PPI;
        end else if (tlb_path && is_store && !hit_page.d) begin
            raw_valid = 1'b1;
            raw_ecode = ECODE_PME;
        end
    end

    always_comb begin
        excp = '0;
        if (en && raw_valid) begin
            excp.valid    = 1'b1;
            excp.ecode    = raw_ecode;
            excp.esubcode = 9'd0;
            excp.badv     = va;
        end
    end

    // ------------------------------------------------------------------
    // TLB refill counter (wraps naturally at 2^32)
    // ------------------------------------------------------------------
    logic        tlbr_report;
    logic [31:0] tlb_miss_cnt_reg;

    assign tlbr_report = excp.valid & (excp.ecode == ECODE_TLBR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlb_miss_cnt_reg <= 32'd0;
        end else if (tlbr_report) begin
            tlb_miss_cnt_reg <= tlb_miss_cnt_reg + 32'd1;
        end
    end

    assign tlb_miss_cnt = tlb_miss_cnt_reg;

endmodule

// File: tb/tb_addr_translator.sv
// ----------------------------------------------------------------------------
// tb_addr_translator
//
// Self-checking bench for addr_translator. Each transaction pushes its
// expected pa/mat/excp to a scoreboard queue when driven; the entry is
// popped and compared once the combinational outputs have settled.
// ----------------------------------------------------------------------------
module tb_addr_translator;
    import addr_translator_pkg::*;

    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] va;
    logic [1:0]  lookup_type;
    logic [1:0]  byte_type;
    csr_t        rd_csr;
    tlb_entry_t  tlb_entrys [N];
    logic [1:0]  mat;
    logic [31:0] pa;
    excp_pass_t  excp;
    logic [31:0] tlb_miss_cnt;

    addr_translator #(.TLB_ENTRY_NUM(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .va           (va),
        .lookup_type  (lookup_type),
        .byte_type    (byte_type),
        .rd_csr       (rd_csr),
        .tlb_entrys   (tlb_entrys),
        .mat          (mat),
        .pa           (pa),
        .excp         (excp),
        .tlb_miss_cnt (tlb_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pa;
        logic [1:0]  mat;
        logic        valid;
        logic [5:0]  ecode;
        logic [31:0] badv;
    } exp_t;

    exp_t  sb_q  [$];
    string tag_q [$];

    int check_cnt = 0;
    int err_cnt   = 0;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        check_cnt++;
        if (observed !== expected) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one access, record its expectation, then compare after settle.
    task automatic txn(input string tag, input logic [1:0] lt, input logic [1:0] bt,
                       input logic [31:0] va_v, input logic en_v,
                       input logic [31:0] exp_pa, input logic [1:0] exp_mat,
                       input logic exp_valid, input logic [5:0] exp_ecode);
        exp_t e;
        exp_t got;
        string t;
        @(negedge clk);
        lookup_type = lt;
        byte_type   = bt;
        va          = va_v;
        en          = en_v;
        e.pa    = exp_pa;
        e.mat   = exp_mat;
        e.valid = exp_valid;
        e.ecode = exp_valid ? exp_ecode : 6'd0;
        e.badv  = exp_valid ? va_v : 32'd0;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        got = sb_q.pop_front();
        t   = tag_q.pop_front();
        check({t, ".pa"},    {32'd0, pa},            {32'd0, got.pa});
        check({t, ".mat"},   {62'd0, mat},           {62'd0, got.mat});
        check({t, ".valid"}, {63'd0, excp.valid},    {63'd0, got.valid});
        check({t, ".ecode"}, {58'd0, excp.ecode},    {58'd0, got.ecode});
        check({t, ".esub"},  {55'd0, excp.esubcode}, 64'd0);
        check({t, ".badv"},  {32'd0, excp.badv},     {32'd0, got.badv});
        $display("txn %-12s va=%08h pa=%08h mat=%0d valid=%0b ecode=%02h",
                 t, va_v, pa, mat, excp.valid, excp.ecode);
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        va          = 32'd0;
        lookup_type = LT_LOAD;
        byte_type   = BT_WORD;
        rd_csr      = '0;
        for (int i = 0; i < N; i++) tlb_entrys[i] = '0;

        #3;
        check("reset.cnt", {32'd0, tlb_miss_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Direct mode
        rd_csr.crmd.da   = 1'b1;
        rd_csr.crmd.datm = 2'd1;
        rd_csr.crmd.datf = 2'd2;
        txn("da_load",   LT_LOAD,  BT_WORD, 32'h1C000100, 1'b1, 32'h1C000100, 2'd1, 1'b0, 6'h00);
        txn("da_fetch",  LT_FETCH, BT_WORD, 32'h1C000104, 1'b1, 32'h1C000104, 2'd2, 1'b0, 6'h00);
        txn("da_adef",   LT_FETCH, BT_WORD, 32'h1C000102, 1'b1, 32'h1C000102, 2'd2, 1'b1, 6'h08);

        // Mapped mode, DMW
        rd_csr.crmd.da   = 1'b0;
        rd_csr.crmd.pg   = 1'b1;
        rd_csr.crmd.plv  = 2'd0;
        rd_csr.dmw0.vseg = 3'd5;
        rd_csr.dmw0.pseg = 3'd0;
        rd_csr.dmw0.plv0 = 1'b1;
        rd_csr.dmw0.mat  = 2'd1;
        rd_csr.dmw1.vseg = 3'd5;
        rd_csr.dmw1.pseg = 3'd3;
        rd_csr.dmw1.plv0 = 1'b1;
        rd_csr.dmw1.plv3 = 1'b1;
        rd_csr.dmw1.mat  = 2'd2;
        txn("dmw0",      LT_LOAD,  BT_WORD, 32'hA0001234, 1'b1, 32'h00001234, 2'd1, 1'b0, 6'h00);
        rd_csr.crmd.plv  = 2'd3;
        txn("dmw1_plv3", LT_LOAD,  BT_WORD, 32'hA0001234, 1'b1, 32'h60001234, 2'd2, 1'b0, 6'h00);
        rd_csr.crmd.plv  = 2'd0;

        // Alignment beats TLB miss; plain misses
        txn("ale_half",  LT_LOAD,  BT_HALF, 32'h00000003, 1'b1, 32'h00000003, 2'd0, 1'b1, 6'h09);
        txn("tlbr",      LT_LOAD,  BT_WORD, 32'h00000004, 1'b1, 32'h00000004, 2'd0, 1'b1, 6'h3F);
        txn("byte_odd",  LT_LOAD,  BT_BYTE, 32'h00000005, 1'b1, 32'h00000005, 2'd0, 1'b1, 6'h3F);
        txn("bt_rsvd",   LT_STORE, 2'b11,   32'h00000007, 1'b1, 32'h00000007, 2'd0, 1'b1, 6'h3F);
        txn("en0_miss",  LT_LOAD,  BT_WORD, 32'h00000004, 1'b0, 32'h00000004, 2'd0, 1'b0, 6'h00);

        // TLB hit via entry 3 (odd 4 KiB page)
        tlb_entrys[3].e      = 1'b1;
        tlb_entrys[3].g      = 1'b1;
        tlb_entrys[3].ps     = 6'd12;
        tlb_entrys[3].vppn   = 19'h00010;
        tlb_entrys[3].p1.ppn = 20'h12345;
        tlb_entrys[3].p1.v   = 1'b1;
        tlb_entrys[3].p1.d   = 1'b1;
        tlb_entrys[3].p1.plv = 2'd3;
        tlb_entrys[3].p1.mat = 2'd1;
        txn("tlb_hit",   LT_LOAD,  BT_WORD, 32'h00021ABC, 1'b1, 32'h12345ABC, 2'd1, 1'b0, 6'h00);
        tlb_entrys[3].p1.d   = 1'b0;
        txn("pme",       LT_STORE, BT_WORD, 32'h00021ABC, 1'b1, 32'h12345ABC, 2'd1, 1'b1, 6'h04);
        tlb_entrys[3].p1.v   = 1'b0;
        txn("pis_prio",  LT_STORE, BT_WORD, 32'h00021ABC, 1'b1, 32'h12345ABC, 2'd1, 1'b1, 6'h02);
        txn("pif",       LT_FETCH, BT_WORD, 32'h00021ABC, 1'b1, 32'h12345ABC, 2'd1, 1'b1, 6'h03);
        txn("pil",       LT_LOAD,  BT_WORD, 32'h00021ABC, 1'b1, 32'h12345ABC, 2'd1, 1'b1, 6'h01);
        tlb_entrys[3].p1.v   = 1'b1;
        tlb_entrys[3].p1.d   = 1'b1;
        tlb_entrys[3].p1.plv = 2'd0;
        rd_csr.crmd.plv      = 2'd3;
        txn("ppi",       LT_LOAD,  BT_WORD, 32'h00021ABC, 1'b1, 32'h12345ABC, 2'd1, 1'b1, 6'h07);
        rd_csr.crmd.plv      = 2'd0;
        tlb_entrys[3].p1.plv = 2'd3;

        // Lower-index duplicate wins; then ASID gating
        tlb_entrys[1]        = tlb_entrys[3];
        tlb_entrys[1].p1.ppn = 20'h0AAAA;
        tlb_entrys[1].p1.mat = 2'd0;
        txn("multi_low", LT_LOAD,  BT_WORD, 32'h00021ABC, 1'b1, 32'h0AAAAABC, 2'd0, 1'b0, 6'h00);
        tlb_entrys[1].g      = 1'b0;
        tlb_entrys[1].asid   = 10'd5;
        rd_csr.asid.asid     = 10'd6;
        txn("asid_miss", LT_LOAD,  BT_WORD, 32'h00021ABC, 1'b1, 32'h12345ABC, 2'd1, 1'b0, 6'h00);
        rd_csr.asid.asid     = 10'd5;
        txn("asid_hit",  LT_LOAD,  BT_WORD, 32'h00021ABC, 1'b1, 32'h0AAAAABC, 2'd0, 1'b0, 6'h00);
        tlb_entrys[1].p0.ppn = 20'h00777;
        tlb_entrys[1].p0.mat = 2'd1;
        tlb_entrys[1].p0.v   = 1'b1;
        tlb_entrys[1].p0.d   = 1'b1;
        tlb_entrys[1].p0.plv = 2'd3;
        txn("even_page", LT_LOAD,  BT_WORD, 32'h00020ABC, 1'b1, 32'h00777ABC, 2'd1, 1'b0, 6'h00);

        // 4 MiB page in entry 0
        tlb_entrys[0].e      = 1'b1;
        tlb_entrys[0].g      = 1'b1;
        tlb_entrys[0].ps     = 6'd21;
        tlb_entrys[0].vppn   = 19'h20200;
        tlb_entrys[0].p1.ppn = 20'hABCDE;
        tlb_entrys[0].p1.v   = 1'b1;
        tlb_entrys[0].p1.d   = 1'b1;
        tlb_entrys[0].p1.plv = 2'd3;
        tlb_entrys[0].p1.mat = 2'd1;
        txn("big_page",  LT_LOAD,  BT_WORD, 32'h40612344, 1'b1, 32'hABC12344, 2'd1, 1'b0, 6'h00);

        // da=0, pg=0 behaves as direct
        rd_csr.crmd.pg = 1'b0;
        txn("illegal_dir", LT_LOAD, BT_WORD, 32'h00000004, 1'b1, 32'h00000004, 2'd1, 1'b0, 6'h00);
        rd_csr.crmd.pg = 1'b1;

        // Miss counter: clear, three counted misses, an uncounted one, async clear
        @(negedge clk);
        lookup_type = LT_LOAD;
        byte_type   = BT_WORD;
        va          = 32'h00000004;
        en          = 1'b1;
        rst         = 1'b1;
        #1;
        check("cnt.clear", {32'd0, tlb_miss_cnt}, 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cnt.three", {32'd0, tlb_miss_cnt}, 64'd3);
        $display("cnt after 3 misses = %0d", tlb_miss_cnt);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("cnt.en0", {32'd0, tlb_miss_cnt}, 64'd3);
        $display("cnt after en=0 miss = %0d", tlb_miss_cnt);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("cnt.four", {32'd0, tlb_miss_cnt}, 64'd4);
        rst = 1'b1;
        #1;
        check("cnt.async_rst", {32'd0, tlb_miss_cnt}, 64'd0);
        $display("cnt after async rst = %0d", tlb_miss_cnt);
        rst = 1'b0;
        en  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
